// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: takes a length-prefixed byte stream, packs big-endian
// words into instruction memory from address 0 and releases the CPU once the image is in.
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR} state_t;

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] n_words;
    logic [17:0] byte_cnt;
    logic [15:0] word_idx;
    logic [31:0] asm_word;

    logic        xfer;
    logic [15:0] n_next;
    logic [17:0] byte_cnt_nx;
    logic [31:0] word_nx;

    assign xfer        = rx_valid & rx_ready;
    assign n_next      = {len_hi, rx_data};
    assign byte_cnt_nx = byte_cnt + 18'd1;
    assign word_nx     = {asm_word[23:0], rx_data};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            len_hi     <= 8'd0;
            n_words    <= 16'd0;
            byte_cnt   <= 18'd0;
            word_idx   <= 16'd0;
            asm_word   <= 32'd0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LEN_HI;
                        rx_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= rx_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        n_words  <= n_next;
                        byte_cnt <= 18'd0;
                        word_idx <= 16'd0;
                        asm_word <= 32'd0;
                        if (n_next == 16'd0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
                        end else if ({1'b0, n_next} > 17'(DEPTH)) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        asm_word <= word_nx;
                        byte_cnt <= byte_cnt_nx;
                        // Fourth byte of a word completes it; write lands the following cycle.
                        if (byte_cnt[1:0] == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx[ADDR_W-1:0];
                            imem_wdata <= word_nx;
                            word_idx   <= word_idx + 16'd1;
                        end
                        if (byte_cnt_nx == {n_words, 2'b00})
                            rx_ready <= 1'b0;
                    end
                    // word_idx has already advanced past the word being written.
                    if (imem_we && word_idx == n_words) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        state    <= LEN_HI;
                        rx_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued by the stimulus
// and popped by a monitor whenever imem_we is seen.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold, busy, done, error;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    logic prev_we = 1'b0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic [7:0] img [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                             8'h01, 8'h09, 8'h50, 8'h20};

    imem_boot_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_t e;
            we_count++;
            chk("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {24'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {24'd0, imem_addr}, {24'd0, e.addr});
                chk("write_data", imem_wdata, e.data);
            end
        end
        prev_we = imem_we;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (gap > 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'hA5;
            repeat (gap) begin
                @(negedge clk);
                chk("rx_ready_in_gap", {31'd0, rx_ready}, 32'd1);
                @(posedge clk); #1;
            end
        end
    endtask

    // Full two-word image; start_at >= 0 pulses start alongside that byte.
    task automatic load_image(input int gap, input int start_at);
        pulse_start();
        exp_q.push_back('{addr: 8'd0, data: 32'h2008_0005});
        exp_q.push_back('{addr: 8'd1, data: 32'h0109_5020});
        for (int i = 0; i < 10; i++) begin
            if (i == start_at) start = 1'b1;
            send_byte(img[i], (i == 9) ? 0 : gap);
            start = 1'b0;
        end
        rx_data = 8'hEE;
        @(negedge clk);
        chk("done_T1", {31'd0, done}, 32'd0);
        chk("hold_T1", {31'd0, cpu_hold}, 32'd1);
        chk("ready_after_last", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        chk("done_T2", {31'd0, done}, 32'd1);
        chk("hold_T2", {31'd0, cpu_hold}, 32'd0);
        chk("busy_T2", {31'd0, busy}, 32'd0);
        rx_valid = 1'b0;
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
        chk({tag, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Test 1: back-to-back bytes
        base = we_count;
        load_image(0, -1);
        chk("t1_we_count", we_count - base, 32'd2);

        // Test 2: 3-cycle gaps between bytes
        base = we_count;
        load_image(3, -1);
        chk("t2_we_count", we_count - base, 32'd2);

        // Test 3: empty image
        base = we_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_we_count", we_count - base, 32'd0);

        // Test 4: oversize header, then recovery
        base = we_count;
        @(posedge clk); #1;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        rx_data = 8'h77;
        @(negedge clk);
        chk("t4_error", {31'd0, error}, 32'd1);
        chk("t4_ready", {31'd0, rx_ready}, 32'd0);
        chk("t4_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t4_done", {31'd0, done}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t4_we_count", we_count - base, 32'd0);
        chk("t4_ready_held", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        load_image(0, -1);
        chk("t4_error_cleared", {31'd0, error}, 32'd0);

        // Test 5: reset after 5 bytes, then clean reload
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(img[i], 0);
        rx_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("t5");
        reset = 1'b1;
        @(posedge clk); #1;
        load_image(0, -1);

        // Test 6: start mid-DATA ignored; start in DONE restarts
        load_image(0, 5);
        pulse_start();
        @(negedge clk);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        chk("t6_ready", {31'd0, rx_ready}, 32'd1);

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
